// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronizes a raw keyed line, measures mark/space run
// lengths in units of UNIT_CYCLES, assembles dot/dash codes, decodes them to
// ASCII (A-Z, 0-9, word space) and queues the characters in a
// first-word-fall-through FIFO.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_data_morse raw keyed line (1 = mark), asynchronous to i_clk
//   o_data       ASCII character at the FIFO head (0 when empty)
//   o_valid      o_data holds a character
//   i_ready      consumer takes o_data when o_valid & i_ready
//   o_the_end    sticky: END_ASCII was decoded; decoder stops listening
//   o_overflow   sticky: a character was dropped on a full FIFO
//   o_level      FIFO occupancy, saturated at 7
module morse_rx_decoder #(
  parameter int          UNIT_CYCLES = 4,
  parameter int          CNT_W       = 8,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [7:0]  END_ASCII   = 8'h31
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data_morse,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_the_end,
  output logic       o_overflow,
  output logic [2:0] o_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DOT_MIN   = CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] TWO_UNITS = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;

  // Code layout: element i (in order of reception) sits at bit i, with a
  // single 1 marking the position just above the last element.
  function automatic logic [7:0] decode_code(input logic [6:0] code, input logic ovf);
    logic [7:0] ch;
    ch = 8'h3F;
    if (!ovf) begin
      case (code)
        7'd6:  ch = 8'h41;  7'd17: ch = 8'h42;  7'd21: ch = 8'h43;  7'd9:  ch = 8'h44;
        7'd2:  ch = 8'h45;  7'd20: ch = 8'h46;  7'd11: ch = 8'h47;  7'd16: ch = 8'h48;
        7'd4:  ch = 8'h49;  7'd30: ch = 8'h4A;  7'd13: ch = 8'h4B;  7'd18: ch = 8'h4C;
        7'd7:  ch = 8'h4D;  7'd5:  ch = 8'h4E;  7'd15: ch = 8'h4F;  7'd22: ch = 8'h50;
        7'd27: ch = 8'h51;  7'd10: ch = 8'h52;  7'd8:  ch = 8'h53;  7'd3:  ch = 8'h54;
        7'd12: ch = 8'h55;  7'd24: ch = 8'h56;  7'd14: ch = 8'h57;  7'd25: ch = 8'h58;
        7'd29: ch = 8'h59;  7'd19: ch = 8'h5A;
        7'd63: ch = 8'h30;  7'd62: ch = 8'h31;  7'd60: ch = 8'h32;  7'd56: ch = 8'h33;
        7'd48: ch = 8'h34;  7'd32: ch = 8'h35;  7'd33: ch = 8'h36;  7'd35: ch = 8'h37;
        7'd39: ch = 8'h38;  7'd47: ch = 8'h39;
        default: ch = 8'h3F;
      endcase
    end
    return ch;
  endfunction

  logic             sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
  logic [CNT_W-1:0] run_q, run_d;
  state_t           state_q, state_d, space_q, space_d;
  logic [6:0]       code_q, code_d;
  logic [2:0]       elem_cnt_q, elem_cnt_d, elem_nxt;
  logic             code_ovf_q, code_ovf_d;
  logic             the_end_q, the_end_d, overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic             rise, fall, push_req, pop, full, wr_en;
  logic [7:0]       push_char, decoded_char;

  assign rise         = sync2_q & ~s_prev_q;
  assign fall         = ~sync2_q & s_prev_q;
  assign elem_nxt     = elem_cnt_q + 3'd1;
  assign decoded_char = decode_code(code_q, code_ovf_q);

  // Synchronizer and run-length counter (counts cycles since the last edge
  // of the synchronized line, restarting at 1).
  always_comb begin
    sync1_d  = i_data_morse;
    sync2_d  = sync1_q;
    s_prev_d = sync2_q;
    if (sync2_q != s_prev_q)  run_d = CNT_W'(1);
    else if (run_q >= RUN_MAX) run_d = RUN_MAX;
    else                       run_d = run_q + CNT_W'(1);
  end

  // Symbol FSM. space_q remembers which space state a mark started from so a
  // glitch can be undone without disturbing the pending character.
  always_comb begin
    state_d    = state_q;
    space_d    = space_q;
    code_d     = code_q;
    elem_cnt_d = elem_cnt_q;
    code_ovf_d = code_ovf_q;
    push_req   = 1'b0;
    push_char  = 8'h00;
    case (state_q)
      IDLE: begin
        if (rise && !the_end_q) begin
          state_d = MARK;
          space_d = IDLE;
        end
      end
      MARK: begin
        if (fall) begin
          if (run_q < DOT_MIN) begin
            state_d = space_q;
          end else begin
            if (elem_cnt_q == 3'd6) begin
              code_ovf_d = 1'b1;
            end else begin
              code_d[elem_cnt_q] = (run_q >= TWO_UNITS);
              code_d[elem_nxt]   = 1'b1;
              elem_cnt_d         = elem_nxt;
            end
            state_d = GAP;
          end
        end
      end
      GAP: begin
        // A rise landing exactly on the threshold still ends the character.
        if (run_q >= TWO_UNITS) begin
          push_req   = 1'b1;
          push_char  = decoded_char;
          code_d     = 7'd1;
          elem_cnt_d = 3'd0;
          code_ovf_d = 1'b0;
          if (decoded_char == END_ASCII) begin
            state_d = IDLE;
          end else if (rise) begin
            state_d = MARK;
            space_d = WORD;
          end else begin
            state_d = WORD;
          end
        end else if (rise) begin
          state_d = MARK;
          space_d = GAP;
        end
      end
      WORD: begin
        if (run_q >= RUN_MAX) begin
          push_req  = 1'b1;
          push_char = 8'h20;
          state_d   = rise ? MARK : IDLE;
          space_d   = IDLE;
        end else if (rise) begin
          state_d = MARK;
          space_d = WORD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO. A push into a full FIFO is accepted only if the head leaves
  // in the same cycle.
  always_comb begin
    pop        = o_valid & i_ready;
    full       = (count_q == DEPTH_C);
    wr_en      = push_req & (~full | pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    the_end_d  = the_end_q | (push_req & (push_char == END_ASCII));
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_char;
  end

  always_comb begin
    o_valid    = (count_q != '0);
    o_data     = o_valid ? mem_q[rd_ptr_q] : 8'h00;
    o_the_end  = the_end_q;
    o_overflow = overflow_q;
    o_level    = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      s_prev_q   <= 1'b0;
      run_q      <= '0;
      state_q    <= IDLE;
      space_q    <= IDLE;
      code_q     <= 7'd1;
      elem_cnt_q <= 3'd0;
      code_ovf_q <= 1'b0;
      the_end_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      s_prev_q   <= s_prev_d;
      run_q      <= run_d;
      state_q    <= state_d;
      space_q    <= space_d;
      code_q     <= code_d;
      elem_cnt_q <= elem_cnt_d;
      code_ovf_q <= code_ovf_d;
      the_end_q  <= the_end_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Character storage carries no reset; o_data is masked while empty.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
module tb_morse_rx_decoder;
  localparam int U = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_data_morse = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_the_end, o_overflow;
  logic [2:0] o_level;

  morse_rx_decoder #(.UNIT_CYCLES(U), .CNT_W(8), .FIFO_DEPTH(8), .END_ASCII(8'h31)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_morse(i_data_morse),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_the_end(o_the_end), .o_overflow(o_overflow), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic lvl; int len; } run_t;
  run_t       runs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         ready_mode = 1;  // 0 stall, 1 always ready, 2 random
  logic       stall_p = 1'b0;
  logic [7:0] data_p = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: ready is updated just after each rising edge.
  initial begin
    forever begin
      @(posedge i_clk); #1;
      case (ready_mode)
        0:       i_ready = 1'b0;
        1:       i_ready = 1'b1;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Capture accepted characters and check the head holds while stalled.
  always @(negedge i_clk) begin
    if (i_rst_n && stall_p) chk("hold", 32'({o_valid, o_data}), 32'({1'b1, data_p}));
    if (i_rst_n && o_valid && i_ready) got_q.push_back(o_data);
    stall_p = i_rst_n && o_valid && !i_ready;
    data_p  = o_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lookup(input string code);
    if (code.len() > 6) return 8'h3F;
    case (code)
      ".-": return 8'h41;    "-...": return 8'h42;  "-.-.": return 8'h43;  "-..": return 8'h44;
      ".": return 8'h45;     "..-.": return 8'h46;  "--.": return 8'h47;   "....": return 8'h48;
      "..": return 8'h49;    ".---": return 8'h4A;  "-.-": return 8'h4B;   ".-..": return 8'h4C;
      "--": return 8'h4D;    "-.": return 8'h4E;    "---": return 8'h4F;   ".--.": return 8'h50;
      "--.-": return 8'h51;  ".-.": return 8'h52;   "...": return 8'h53;   "-": return 8'h54;
      "..-": return 8'h55;   "...-": return 8'h56;  ".--": return 8'h57;   "-..-": return 8'h58;
      "-.--": return 8'h59;  "--..": return 8'h5A;
      "-----": return 8'h30; ".----": return 8'h31; "..---": return 8'h32; "...--": return 8'h33;
      "....-": return 8'h34; ".....": return 8'h35; "-....": return 8'h36; "--...": return 8'h37;
      "---..": return 8'h38; "----.": return 8'h39;
      default: return 8'h3F;
    endcase
  endfunction

  // Reference: walk the list of line runs. Marks shorter than U/2 vanish,
  // shorter than 2U are dots, else dashes. A space run of 2U ends a pending
  // character; a run of 5U after a character adds one word space.
  task automatic model_runs();
    string code = "";
    int    st = 0;  // 0 nothing pending, 1 character pending, 2 space owed
    logic [7:0] c;
    exp_q.delete();
    foreach (runs_q[i]) begin
      if (runs_q[i].lvl) begin
        if (runs_q[i].len >= U / 2) begin
          code = {code, (runs_q[i].len >= 2 * U) ? "-" : "."};
          st = 1;
        end
      end else begin
        if (st == 1 && runs_q[i].len >= 2 * U) begin
          c = lookup(code);
          exp_q.push_back(c);
          code = "";
          if (c == 8'h31) break;
          st = 2;
        end
        if (st == 2 && runs_q[i].len >= 5 * U) begin
          exp_q.push_back(8'h20);
          st = 0;
        end
      end
    end
  endtask

  task automatic add_run(input logic lvl, input int len);
    runs_q.push_back('{lvl: lvl, len: len});
  endtask

  task automatic add_symbol(input string pat, input int gap);
    for (int i = 0; i < pat.len(); i++) begin
      add_run(1'b1, (pat[i] == "-") ? 3 * U : U);
      add_run(1'b0, (i == pat.len() - 1) ? gap : U);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_data_morse = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_end", 32'(o_the_end), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_level", 32'(o_level), 0);
    i_rst_n = 1'b1;
    got_q.delete();
    runs_q.delete();
    add_run(1'b0, 5);
  endtask

  task automatic drive_runs();
    foreach (runs_q[i]) begin
      i_data_morse = runs_q[i].lvl;
      repeat (runs_q[i].len) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int idle = 0;
    int t = 0;
    while (idle < 8 && t < 3000) begin
      @(posedge i_clk); #1;
      t++;
      if (o_valid) idle = 0; else idle++;
    end
    if (t >= 3000) chk({tag, "_drain_timeout"}, 1, 0);
  endtask

  task automatic compare_stream(input string tag, input int n);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({tag, "_char"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_scenario(input string tag);
    model_runs();
    drive_runs();
    wait_drain(tag);
    compare_stream(tag, exp_q.size());
  endtask

  initial begin
    // Dot-dash with the letter gap inside a longer low run: 'A' then space.
    ready_mode = 1;
    do_reset();
    add_symbol(".-", 30);
    run_scenario("a_space");
    chk("a_no_end", 32'(o_the_end), 0);

    // Letter gap exactly 2U separates 'S' from 'T' without a space.
    do_reset();
    add_symbol("...", 2 * U);
    add_symbol("-", 30);
    run_scenario("s_t");

    // One-cycle mark inside a short gap is discarded: "-.." -> 'D'.
    do_reset();
    add_run(1'b1, 3 * U); add_run(1'b0, 1); add_run(1'b1, 1); add_run(1'b0, 1);
    add_run(1'b1, U); add_run(1'b0, U); add_run(1'b1, U); add_run(1'b0, 30);
    run_scenario("glitch_d");

    // Seven dots give '?'; ".----" ends the message; later input is ignored.
    do_reset();
    add_symbol(".......", 2 * U);
    add_symbol(".----", 2 * U);
    add_symbol(".", 30);
    run_scenario("end_msg");
    chk("end_flag", 32'(o_the_end), 1);

    // Nine 'T' with the consumer stalled: 8 held, the rest dropped.
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 9; i++) add_symbol("-", (i == 8) ? 30 : 2 * U);
    model_runs();
    drive_runs();
    repeat (5) @(posedge i_clk);
    #1;
    chk("full_level", 32'(o_level), 7);
    chk("full_ovf", 32'(o_overflow), 1);
    chk("full_valid", 32'(o_valid), 1);
    chk("full_head", 32'(o_data), 32'(exp_q[0]));
    ready_mode = 2;
    wait_drain("drain");
    compare_stream("drain", 8);

    // Reset in the middle of a dash, then "..-".
    do_reset();
    i_data_morse = 1'b1;
    repeat (6) @(posedge i_clk);
    #3;
    do_reset();
    chk("rst_mid_empty", 32'(got_q.size()), 0);
    add_symbol("..-", 30);
    run_scenario("after_rst");

    // Random element/gap lengths, including glitches and overlong codes.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ready_mode = 2;
      for (int c = 0; c < 12; c++) begin
        int ne;
        ne = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(1, 5));
        for (int e = 0; e < ne; e++) begin
          int k;
          k = int'($urandom_range(0, 9));
          add_run(1'b1, (k == 0) ? 1 : (k < 5) ? int'($urandom_range(2, 7)) : int'($urandom_range(8, 14)));
          if (e != ne - 1) add_run(1'b0, int'($urandom_range(1, 7)));
        end
        if (c == 11) add_run(1'b0, 30);
        else if ($urandom_range(0, 2) == 0) add_run(1'b0, int'($urandom_range(20, 26)));
        else add_run(1'b0, int'($urandom_range(8, 19)));
      end
      run_scenario("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
